// File: rtl/divider_sequencer_pkg.sv
// Shared types and constants for the divider sequencer.
package divider_sequencer_pkg;

    localparam int STAGES  = 7;
    localparam int BURST_W = 8;
    localparam int SEL_W   = 3;

    // Highest legal tap index; a request for 7 is clamped to this.
    localparam logic [SEL_W-1:0] SEL_MAX = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Mask covering counter bits [k:0]; all ones there marks the last cycle of a tap-k period.
    function automatic logic [STAGES-1:0] tap_mask(input logic [SEL_W-1:0] k);
        logic [STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < STAGES; i++) begin
            m[i] = (i <= int'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/divider_sequencer_if.sv
// Tap-select handshake.
// A transfer happens on a rising clk edge where sel_valid && sel_ready; the
// master holds sel stable while sel_valid is high, and sel_ready never depends
// combinationally on sel_valid.
interface divider_sequencer_if;

    logic                                   sel_valid;
    logic [divider_sequencer_pkg::SEL_W-1:0] sel;
    logic                                   sel_ready;

    modport master (output sel_valid, output sel, input sel_ready);
    modport slave  (input sel_valid, input sel, output sel_ready);

endinterface

// File: rtl/divider_sequencer_div_counter.sv
// Free-running divider counter with clear/enable and a period-end flag for the selected tap.
module div_counter
    import divider_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [SEL_W-1:0]  tap,
    output logic [STAGES-1:0] cnt,
    output logic [STAGES-1:0] cnt_inc,
    output logic              period_end
);

    assign cnt_inc    = cnt + 1'b1;
    assign period_end = ((cnt & tap_mask(tap)) == tap_mask(tap));

    // Counter register: clear wins over enable; otherwise wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/divider_sequencer.sv
// Glitch-free power-of-two clock divider controller with start/stop, bursts
// and tap changes applied only at period boundaries.
module divider_sequencer
    import divider_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [BURST_W-1:0]   burst_len,
    divider_sequencer_if.slave   sel_if,
    output logic                 clk_out,
    output logic [STAGES-1:0]    tap_div,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output state_t               state_dbg
);

    state_t             state_q, state_d;
    logic               pend_valid_q;
    logic [SEL_W-1:0]   pend_sel_q;
    logic               stop_seen_q;
    logic [BURST_W-1:0] burst_q, pcnt_q;
    logic [STAGES-1:0]  cnt, cnt_inc;
    logic               period_end;
    logic               run, pe, accept, stop_req, burst_last, finish;
    logic               apply_sel, cnt_clr, clk_out_d, done_d;

    div_counter u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .en         (run),
        .tap        (cur_sel),
        .cnt        (cnt),
        .cnt_inc    (cnt_inc),
        .period_end (period_end)
    );

    assign run        = (state_q == RUN);
    assign pe         = run && period_end;
    assign accept     = sel_if.sel_valid && sel_if.sel_ready;
    assign stop_req   = stop_seen_q || stop;
    assign burst_last = (burst_q != '0) && (pcnt_q == burst_q - 1'b1);
    assign finish     = pe && (stop_req || burst_last);

    assign sel_if.sel_ready = !pend_valid_q;
    assign tap_div          = cnt;
    assign state_dbg        = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start leaves IDLE, a terminating period end leaves RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = RUN;
            RUN:     if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs/controls: restart the count whenever the phase must begin fresh.
    always_comb begin
        apply_sel = pend_valid_q && (!run || pe);
        cnt_clr   = !run || finish || (pe && pend_valid_q);
        clk_out_d = cnt_clr ? 1'b0 : cnt_inc[cur_sel];
        done_d    = finish;
        busy      = run;
    end

    // Divided clock and done pulse are registered so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            clk_out <= clk_out_d;
            done    <= done_d;
        end
    end

    // One-entry pending select, current tap and sticky illegal-select flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_sel_q   <= '0;
            cur_sel      <= '0;
            err          <= 1'b0;
        end else begin
            if (apply_sel) begin
                cur_sel      <= pend_sel_q;
                pend_valid_q <= 1'b0;
            end else if (accept) begin
                pend_valid_q <= 1'b1;
                pend_sel_q   <= (sel_if.sel > SEL_MAX) ? SEL_MAX : sel_if.sel;
            end
            if (accept && (sel_if.sel > SEL_MAX)) begin
                err <= 1'b1;
            end
        end
    end

    // Burst length latch, saturating period counter and remembered stop request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q     <= '0;
            pcnt_q      <= '0;
            stop_seen_q <= 1'b0;
        end else if (!run) begin
            stop_seen_q <= 1'b0;
            if (start) begin
                burst_q <= burst_len;
                pcnt_q  <= '0;
            end
        end else if (pe) begin
            stop_seen_q <= 1'b0;
            if (pcnt_q != '1) begin
                pcnt_q <= pcnt_q + 1'b1;
            end
        end else if (stop) begin
            stop_seen_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// Self-checking bench for divider_sequencer: cycle-count reference model plus directed scenarios.
module tb_divider_sequencer;
    import divider_sequencer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [BURST_W-1:0] burst_len = '0;
    logic               clk_out;
    logic [STAGES-1:0]  tap_div;
    logic [SEL_W-1:0]   cur_sel;
    logic               busy, done, err;
    state_t             state_dbg;

    divider_sequencer_if sif();

    divider_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .burst_len (burst_len),
        .sel_if    (sif),
        .clk_out   (clk_out),
        .tap_div   (tap_div),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The divider is described as "cycles elapsed in the current phase run":
    // clk_out is bit sel of that count, a period ends every 2^(sel+1) cycles.
    bit m_run, m_pend_v, m_err, m_done, m_stop_seen;
    int m_cyc, m_sel, m_pend, m_burst, m_periods;

    always @(posedge clk or negedge rst_n) begin : model
        bit run_n, pv_n, err_n, done_n, ss_n, pe, ending, acc;
        int cyc_n, sel_n, pend_n, burst_n, per_n;
        if (!rst_n) begin
            m_run <= 0; m_pend_v <= 0; m_err <= 0; m_done <= 0; m_stop_seen <= 0;
            m_cyc <= 0; m_sel <= 0; m_pend <= 0; m_burst <= 0; m_periods <= 0;
        end else begin
            run_n = m_run; pv_n = m_pend_v; err_n = m_err; ss_n = m_stop_seen;
            cyc_n = m_cyc; sel_n = m_sel; pend_n = m_pend; burst_n = m_burst; per_n = m_periods;
            done_n = 0;
            acc = sif.sel_valid && !m_pend_v;
            if (!m_run) begin
                cyc_n = 0;
                if (m_pend_v) begin sel_n = m_pend; pv_n = 0; end
                if (start) begin
                    run_n = 1; burst_n = int'(burst_len); per_n = 0; ss_n = 0;
                end
            end else begin
                pe = ((m_cyc + 1) % (1 << (m_sel + 1))) == 0;
                if (pe) begin
                    if (per_n < 255) per_n++;
                    ending = m_stop_seen || stop || (m_burst != 0 && per_n == m_burst);
                    if (m_pend_v) begin sel_n = m_pend; pv_n = 0; end
                    if (ending) begin
                        run_n = 0; cyc_n = 0; done_n = 1;
                    end else if (m_pend_v) begin
                        cyc_n = 0;
                    end else begin
                        cyc_n = m_cyc + 1;
                    end
                    ss_n = 0;
                end else begin
                    cyc_n = m_cyc + 1;
                    if (stop) ss_n = 1;
                end
            end
            if (acc) begin
                pv_n = 1;
                pend_n = (sif.sel == 3'd7) ? 6 : int'(sif.sel);
                if (sif.sel == 3'd7) err_n = 1;
            end
            m_run <= run_n; m_pend_v <= pv_n; m_err <= err_n; m_done <= done_n;
            m_stop_seen <= ss_n; m_cyc <= cyc_n; m_sel <= sel_n; m_pend <= pend_n;
            m_burst <= burst_n; m_periods <= per_n;
        end
    end

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(negedge clk) begin
        check("cmp_clk_out", int'(clk_out), m_run ? ((m_cyc >> m_sel) & 1) : 0);
        check("cmp_tap_div", int'(tap_div), m_cyc % 128);
        check("cmp_cur_sel", int'(cur_sel), m_sel);
        check("cmp_busy", int'(busy), int'(m_run));
        check("cmp_done", int'(done), int'(m_done));
        check("cmp_err", int'(err), int'(m_err));
        check("cmp_sel_ready", int'(sif.sel_ready), int'(!m_pend_v));
        check("cmp_state", int'(state_dbg), m_run ? int'(RUN) : int'(IDLE));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input int len);
        burst_len = BURST_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic offer_sel(input int v);
        sif.sel_valid = 1'b1;
        sif.sel = SEL_W'(v);
        tick();
        sif.sel_valid = 1'b0;
    endtask

    task automatic stop_and_drain(input string name);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 300 && busy; i++) tick();
        check(name, int'(busy), 0);
        tick();
    endtask

    logic [0:0] exp_q[$];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        sif.sel_valid = 1'b0;
        sif.sel = '0;
        repeat (3) tick();
        #2 rst_n = 1'b1;
        tick();
        check("rst_cur_sel", int'(cur_sel), 0);
        check("rst_sel_ready", int'(sif.sel_ready), 1);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tap_div", int'(tap_div), 0);

        // Tap 0, burst of 3: rises E1,E3,E5, falls E2,E4,E6, done after E6.
        pulse_start(3);
        check("t1_busy_e0", int'(busy), 1);
        check("t1_clk_e0", int'(clk_out), 0);
        for (int k = 1; k <= 7; k++) exp_q.push_back((k <= 6) ? 1'(k % 2) : 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("t1_clk_e%0d", k), int'(clk_out), int'(exp_q.pop_front()));
            if (k == 6) begin
                check("t1_done_e6", int'(done), 1);
                check("t1_busy_e6", int'(busy), 0);
            end
            if (k == 7) check("t1_done_e7", int'(done), 0);
        end

        // Tap 2 free-run, stop sampled at E5 -> ends at E8.
        offer_sel(2);
        tick();
        check("t2_cur_sel", int'(cur_sel), 2);
        pulse_start(0);
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick();
        check("t2_busy_e7", int'(busy), 1);
        check("t2_clk_e7", int'(clk_out), 1);
        check("t2_done_e7", int'(done), 0);
        tick();
        check("t2_busy_e8", int'(busy), 0);
        check("t2_done_e8", int'(done), 1);
        check("t2_clk_e8", int'(clk_out), 0);
        tick();
        check("t2_done_e9", int'(done), 0);

        // Tap 1 running, select 3 offered at E2, applied at E4.
        offer_sel(1);
        tick();
        pulse_start(0);
        tick();
        sif.sel_valid = 1'b1;
        sif.sel = 3'd3;
        tick();
        sif.sel_valid = 1'b0;
        check("t3_ready_e2", int'(sif.sel_ready), 0);
        tick();
        check("t3_ready_e3", int'(sif.sel_ready), 0);
        check("t3_sel_e3", int'(cur_sel), 1);
        tick();
        check("t3_ready_e4", int'(sif.sel_ready), 1);
        check("t3_sel_e4", int'(cur_sel), 3);
        check("t3_cnt_e4", int'(tap_div), 0);
        repeat (7) tick();
        check("t3_clk_e11", int'(clk_out), 0);
        tick();
        check("t3_clk_e12", int'(clk_out), 1);
        repeat (7) tick();
        check("t3_clk_e19", int'(clk_out), 1);
        tick();
        check("t3_clk_e20", int'(clk_out), 0);
        stop_and_drain("t3_stop_timeout");

        // Illegal select 7 in IDLE: clamped to 6, sticky err.
        offer_sel(7);
        check("t4_err_accept", int'(err), 1);
        check("t4_ready_accept", int'(sif.sel_ready), 0);
        tick();
        check("t4_cur_sel", int'(cur_sel), 6);
        check("t4_ready_applied", int'(sif.sel_ready), 1);

        // Stop and burst end coincide at E4 with select 1 pending.
        offer_sel(0);
        tick();
        pulse_start(2);
        tick(); tick();
        stop = 1'b1;
        sif.sel_valid = 1'b1;
        sif.sel = 3'd1;
        tick();
        stop = 1'b0;
        sif.sel_valid = 1'b0;
        check("t5_busy_e3", int'(busy), 1);
        tick();
        check("t5_busy_e4", int'(busy), 0);
        check("t5_done_e4", int'(done), 1);
        check("t5_sel_e4", int'(cur_sel), 1);
        check("t5_clk_e4", int'(clk_out), 0);
        tick();
        check("t5_done_e5", int'(done), 0);
        check("t5_err_sticky", int'(err), 1);

        // Asynchronous reset mid-RUN with a pending select.
        pulse_start(0);
        repeat (3) tick();
        offer_sel(4);
        check("t6_ready_pending", int'(sif.sel_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_clk", int'(clk_out), 0);
        check("t6_rst_tap", int'(tap_div), 0);
        check("t6_rst_sel", int'(cur_sel), 0);
        check("t6_rst_ready", int'(sif.sel_ready), 1);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_err", int'(err), 0);
        tick();
        #2 rst_n = 1'b1;
        tick(); tick();
        check("t6_post_sel", int'(cur_sel), 0);
        check("t6_post_ready", int'(sif.sel_ready), 1);
        check("t6_post_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
